// File: rtl/bird_pkg.sv
// Shared bird/game constants, FSM state encoding and glyph helpers.
package bird_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PLAY  = 2'b01,
    DYING = 2'b10,
    DEAD  = 2'b11
  } bird_state_e;

  // Screen geometry shared with pipe and VGA blocks
  localparam logic [7:0] START_Y = 8'd120;
  localparam logic [7:0] FLOOR_Y = 8'd230;

  // Physics, velocities in pixels per frame (positive is downward)
  localparam logic [2:0]        GRAVITY  = 3'd1;
  localparam logic signed [5:0] FLAP_VEL = -6'sd6;
  localparam logic signed [5:0] MAX_FALL = 6'sd8;

  // Animation
  localparam logic [3:0] GLYPH_FRAMES    = 4'd6;
  localparam logic [1:0] GLYPH_DEAD      = 2'd3;
  localparam logic [1:0] GLYPH_LAST_FLAP = 2'd2;

  // Wing glyph sequence 0 -> 1 -> 2 -> 0; glyph 3 is reserved for dead
  function automatic logic [1:0] next_glyph(input logic [1:0] g);
    return (g == GLYPH_LAST_FLAP) ? 2'd0 : g + 2'd1;
  endfunction

endpackage

// File: rtl/bird_physics.sv
// Combinational one-frame velocity/position step with screen clamp.
module bird_physics
  import bird_pkg::*;
(
  input  logic [7:0]        y_i,
  input  logic signed [5:0] v_i,
  input  logic              flap_i,
  input  logic              force_fall_i,
  output logic signed [5:0] v_o,
  output logic [7:0]        y_o,
  output logic              floor_o
);

  logic signed [5:0] v_inc;
  logic [9:0]        y_sum;

  // Pick the new velocity, then integrate position in 10 bits so that
  // both the negative (ceiling) and past-floor cases are visible.
  always_comb begin
    v_inc = v_i + $signed({3'b000, GRAVITY});
    if (force_fall_i)          v_o = MAX_FALL;
    else if (flap_i)           v_o = FLAP_VEL;
    else if (v_inc > MAX_FALL) v_o = MAX_FALL;
    else                       v_o = v_inc;

    y_sum = {2'b00, y_i} + {{4{v_o[5]}}, v_o};
    if (y_sum[9])                          y_o = 8'd0;     // above ceiling: stick
    else if (y_sum[8:0] > {1'b0, FLOOR_Y}) y_o = FLOOR_Y;
    else                                   y_o = y_sum[7:0];

    floor_o = (y_o == FLOOR_Y);
  end

endmodule

// File: rtl/bird_ctrl.sv
// Per-frame bird sequencer: game FSM, flap latch, wing animation and
// registered sprite outputs for the bird renderer.
module bird_ctrl
  import bird_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       FRAME_TICK,
  input  logic       FLAP,
  input  logic       START,
  input  logic       HIT,
  output logic [7:0] BIRD_Y_POSITION,
  output logic [1:0] BIRD_GLYPH_NUMBER,
  output logic       PLAYING,
  output logic       GAME_OVER
);

  bird_state_e       state_q, state_d;
  logic [7:0]        y_q, y_d;
  logic signed [5:0] v_q, v_d;
  logic [1:0]        glyph_q, glyph_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              latch_q, latch_d;
  logic              flap_prev_q;
  logic              playing_q, game_over_q;

  logic              flap_rise, flap_now;
  logic signed [5:0] phy_v;
  logic [7:0]        phy_y;
  logic              phy_floor;

  // A rise coincident with the tick counts for that tick
  assign flap_rise = FLAP & ~flap_prev_q;
  assign flap_now  = latch_q | flap_rise;

  bird_physics u_phy (
    .y_i          (y_q),
    .v_i          (v_q),
    .flap_i       (flap_now),
    .force_fall_i (state_q == DYING),
    .v_o          (phy_v),
    .y_o          (phy_y),
    .floor_o      (phy_floor)
  );

  // Next-state, physics commit, latch and animation
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    v_d     = v_q;
    glyph_d = glyph_q;
    cnt_d   = cnt_q;
    latch_d = FRAME_TICK ? 1'b0 : (latch_q | flap_rise);

    if (FRAME_TICK && (state_q == IDLE || state_q == PLAY)) begin
      if (cnt_q == GLYPH_FRAMES - 4'd1) begin
        cnt_d   = 4'd0;
        glyph_d = next_glyph(glyph_q);
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end

    case (state_q)
      IDLE: begin
        y_d = START_Y;
        v_d = 6'sd0;
        // Pending flap makes the first PLAY tick launch with FLAP_VEL;
        // it overrides a coincident tick's clear, which does no physics.
        if (START) begin
          state_d = PLAY;
          latch_d = 1'b1;
        end
      end
      PLAY: begin
        if (FRAME_TICK) begin
          v_d = phy_v;
          y_d = phy_y;
          if (phy_floor) begin
            state_d = DEAD;
            glyph_d = GLYPH_DEAD;
          end
        end
        // Collision wins the state choice; the tick's Y update still lands
        if (HIT) begin
          state_d = DYING;
          glyph_d = GLYPH_DEAD;
        end
      end
      DYING: begin
        glyph_d = GLYPH_DEAD;
        if (FRAME_TICK) begin
          v_d = phy_v;
          y_d = phy_y;
          if (phy_floor) state_d = DEAD;
        end
      end
      DEAD: begin
        y_d     = FLOOR_Y;
        glyph_d = GLYPH_DEAD;
        if (START) begin
          state_d = IDLE;
          y_d     = START_Y;
          glyph_d = 2'd0;
          cnt_d   = 4'd0;
          v_d     = 6'sd0;
          latch_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      y_q         <= START_Y;
      v_q         <= 6'sd0;
      glyph_q     <= 2'd0;
      cnt_q       <= 4'd0;
      latch_q     <= 1'b0;
      flap_prev_q <= 1'b0;
      playing_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      y_q         <= y_d;
      v_q         <= v_d;
      glyph_q     <= glyph_d;
      cnt_q       <= cnt_d;
      latch_q     <= latch_d;
      flap_prev_q <= FLAP;
      playing_q   <= (state_d == PLAY);
      game_over_q <= (state_d == DEAD);
    end
  end

  assign BIRD_Y_POSITION   = y_q;
  assign BIRD_GLYPH_NUMBER = glyph_q;
  assign PLAYING           = playing_q;
  assign GAME_OVER         = game_over_q;

endmodule

// File: tb/tb_bird_ctrl.sv
// Directed bench for bird_ctrl with hand-computed trajectories.
module tb_bird_ctrl;

  logic       CLK = 1'b0;
  logic       RST_N, FRAME_TICK, FLAP, START, HIT;
  logic [7:0] y;
  logic [1:0] glyph;
  logic       playing, game_over;

  int nchk = 0;
  int nerr = 0;

  bird_ctrl dut (
    .CLK               (CLK),
    .RST_N             (RST_N),
    .FRAME_TICK        (FRAME_TICK),
    .FLAP              (FLAP),
    .START             (START),
    .HIT               (HIT),
    .BIRD_Y_POSITION   (y),
    .BIRD_GLYPH_NUMBER (glyph),
    .PLAYING           (playing),
    .GAME_OVER         (game_over)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // One clock; return just after the edge so outputs are settled
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic tick();
    FRAME_TICK = 1'b1;
    cyc();
    FRAME_TICK = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic flap_tick();
    FLAP = 1'b1;
    cyc();
    FLAP = 1'b0;
    tick();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_y"},    y, 120);
    chk({tag, "_gl"},   glyph, 0);
    chk({tag, "_play"}, playing, 0);
    chk({tag, "_over"}, game_over, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    RST_N = 1'b0; FRAME_TICK = 1'b0; FLAP = 1'b0; START = 1'b0; HIT = 1'b0;
    repeat (2) cyc();
    chk_idle("reset");
    RST_N = 1'b1;

    // IDLE animation: glyph advances on the 6th tick; HIT ignored
    ticks(5);
    chk("idle_gl5", glyph, 0);
    tick();
    chk("idle_gl6", glyph, 1);
    chk("idle_y", y, 120);
    HIT = 1'b1; cyc(); HIT = 1'b0; cyc();
    chk("idle_hit_play", playing, 0);
    chk("idle_hit_gl", glyph, 1);

    // START then launch trajectory
    START = 1'b1; cyc(); START = 1'b0;
    chk("start_play", playing, 1);
    chk("start_y", y, 120);
    tick(); chk("launch_y1", y, 114);
    tick(); chk("launch_y2", y, 109);
    tick(); chk("launch_y3", y, 105);

    // Repeated flaps walk the bird to Y=3 (26 ticks since reset)
    repeat (17) flap_tick();
    chk("flap_y3", y, 3);
    chk("anim_gl", glyph, 1);

    // Two rises before one tick: a single flap, clamps at the ceiling
    FLAP = 1'b1; cyc(); FLAP = 1'b0; cyc();
    FLAP = 1'b1; cyc(); FLAP = 1'b0;
    tick();
    chk("ceil_y", y, 0);
    chk("ceil_play", playing, 1);
    ticks(6);
    chk("ceil_stick", y, 0);
    tick(); chk("ceil_v1", y, 1);
    tick(); chk("ceil_v2", y, 3);
    tick(); chk("ceil_v3", y, 6);

    // Reset mid-game
    RST_N = 1'b0; cyc(); RST_N = 1'b1;
    chk_idle("midrst");

    // Fall to terminal velocity and onto the floor
    START = 1'b1; cyc(); START = 1'b0;
    ticks(14);
    chk("v7_y", y, 127);
    tick(); chk("sat_y1", y, 135);
    tick(); chk("sat_y2", y, 143);
    tick(); chk("sat_y3", y, 151);
    ticks(9);
    chk("prefloor_y", y, 223);
    chk("prefloor_over", game_over, 0);
    tick();
    chk("floor_y", y, 230);
    chk("floor_over", game_over, 1);
    chk("floor_play", playing, 0);
    chk("floor_gl", glyph, 3);
    START = 1'b1; cyc(); START = 1'b0;
    chk_idle("restart");

    // START coincident with tick: transition only, physics next tick
    START = 1'b1; FRAME_TICK = 1'b1; cyc(); START = 1'b0; FRAME_TICK = 1'b0;
    chk("st_tick_y", y, 120);
    chk("st_tick_play", playing, 1);
    tick(); chk("st_tick_y1", y, 114);
    ticks(4);
    chk("hit_pre_y", y, 100);

    // Collision: DYING falls at MAX_FALL, ignores FLAP and START
    HIT = 1'b1; cyc(); HIT = 1'b0;
    chk("hit_gl", glyph, 3);
    chk("hit_play", playing, 0);
    chk("hit_y", y, 100);
    tick(); chk("dying_y1", y, 108);
    tick(); chk("dying_y2", y, 116);
    flap_tick();
    chk("dying_flap_y", y, 124);
    START = 1'b1; cyc(); START = 1'b0;
    chk("dying_start_y", y, 124);
    chk("dying_start_over", game_over, 0);
    chk("dying_start_play", playing, 0);
    ticks(13);
    chk("dying_y228", y, 228);
    chk("dying_over", game_over, 0);
    tick();
    chk("dead_y", y, 230);
    chk("dead_over", game_over, 1);
    chk("dead_gl", glyph, 3);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
